// File: rtl/bp_pkg.sv
// bp_pkg: shared constants and types for the branch predictor.
//   BP_ENTRIES / BP_IDX_W / BP_TAG_W size the direct-mapped table.
//   bp_ctr_e is the 2-bit saturating-counter encoding; the MSB is the
//   taken/not-taken prediction.
package bp_pkg;

   localparam int BP_ENTRIES = 16;
   localparam int BP_IDX_W   = 4;
   localparam int BP_TAG_W   = 26;

   typedef enum logic [1:0] {
      SNT = 2'b00,   // strongly not taken
      WNT = 2'b01,   // weakly not taken
      WT  = 2'b10,   // weakly taken
      ST  = 2'b11    // strongly taken
   } bp_ctr_e;

endpackage

// File: rtl/bp_sat_ctr2.sv
// bp_sat_ctr2: next-state logic of a 2-bit saturating counter (combinational).
//   ctr_i   - current counter value
//   taken_i - resolved outcome (1 = increment, 0 = decrement)
//   ctr_o   - next counter value, clamped at SNT and ST
module bp_sat_ctr2
   import bp_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   // Step toward the outcome, holding at either end of the range.
   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != ST) begin
            ctr_o = ctr_i + 2'd1;
         end else begin
            ctr_o = ctr_i;
         end
      end else begin
         if (ctr_i != SNT) begin
            ctr_o = ctr_i - 2'd1;
         end else begin
            ctr_o = ctr_i;
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 16-entry direct-mapped branch target buffer with 2-bit
// saturating counters, fetch-stage lookup and decode-stage resolution.
//   clk, rst_n              - clock, asynchronous active-low reset
//   PCF                     - fetch PC used for the combinational lookup
//   StallF, FlushD          - control of the F->D prediction register
//   StallD                  - suppresses table update and misprediction
//   PCD, BranchD, PCSrcD,
//   PCBranchD               - decode instruction and its resolved outcome
//   PreBr, PCPredictF       - fetch prediction (taken flag, next PC)
//   MispredictD, PCRecoverD - decode-stage redirect request and correct PC
// Index = PC[5:2], tag = PC[31:6].
module branch_predictor
   import bp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PCF,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic [31:0] PCD,
   input  logic        BranchD,
   input  logic        PCSrcD,
   input  logic [31:0] PCBranchD,
   output logic        PreBr,
   output logic [31:0] PCPredictF,
   output logic        MispredictD,
   output logic [31:0] PCRecoverD
);

   // Table storage
   logic                valid_q  [BP_ENTRIES];
   logic                valid_d  [BP_ENTRIES];
   logic [BP_TAG_W-1:0] tag_q    [BP_ENTRIES];
   logic [BP_TAG_W-1:0] tag_d    [BP_ENTRIES];
   logic [31:0]         target_q [BP_ENTRIES];
   logic [31:0]         target_d [BP_ENTRIES];
   logic [1:0]          ctr_q    [BP_ENTRIES];
   logic [1:0]          ctr_d    [BP_ENTRIES];

   // F->D prediction register
   logic        pred_taken_q;
   logic        pred_taken_d;
   logic [31:0] pred_target_q;
   logic [31:0] pred_target_d;

   logic [BP_IDX_W-1:0] idx_f;
   logic [BP_IDX_W-1:0] idx_dec;
   logic                hit_f;
   logic                hit_dec;
   logic [1:0]          ctr_upd;

   assign idx_f   = PCF[5:2];
   assign idx_dec = PCD[5:2];
   assign hit_f   = valid_q[idx_f] && (tag_q[idx_f] == PCF[31:6]);
   assign hit_dec = valid_q[idx_dec] && (tag_q[idx_dec] == PCD[31:6]);

   bp_sat_ctr2 u_sat_ctr (
      .ctr_i   (ctr_q[idx_dec]),
      .taken_i (PCSrcD),
      .ctr_o   (ctr_upd)
   );

   // Fetch lookup; gated by rst_n so the outputs are defined during reset.
   always_comb begin
      PreBr      = 1'b0;
      PCPredictF = PCF + 32'd4;
      if (rst_n && hit_f) begin
         PreBr      = ctr_q[idx_f][1];
         PCPredictF = target_q[idx_f];
      end else begin
         PreBr      = 1'b0;
         PCPredictF = PCF + 32'd4;
      end
   end

   // Next value of the F->D register: flush beats stall.
   always_comb begin
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
      if (FlushD) begin
         pred_taken_d  = 1'b0;
         pred_target_d = 32'd0;
      end else if (!StallF) begin
         pred_taken_d  = PreBr;
         pred_target_d = PCPredictF;
      end else begin
         pred_taken_d  = pred_taken_q;
         pred_target_d = pred_target_q;
      end
   end

   // Decode-stage misprediction: wrong direction, wrong target on a
   // correctly predicted taken branch, or a taken prediction on a non-branch.
   always_comb begin
      MispredictD = 1'b0;
      if (rst_n && !StallD) begin
         if (BranchD) begin
            if (PCSrcD != pred_taken_q) begin
               MispredictD = 1'b1;
            end else if (PCSrcD && (PCBranchD != pred_target_q)) begin
               MispredictD = 1'b1;
            end else begin
               MispredictD = 1'b0;
            end
         end else begin
            MispredictD = pred_taken_q;
         end
      end else begin
         MispredictD = 1'b0;
      end
   end

   // Recovery PC is meaningful only while MispredictD is high.
   always_comb begin
      PCRecoverD = PCD + 32'd4;
      if (BranchD && PCSrcD) begin
         PCRecoverD = PCBranchD;
      end else begin
         PCRecoverD = PCD + 32'd4;
      end
   end

   // Table next state: at most one entry, selected by PCD, changes per cycle.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (!StallD) begin
         if (BranchD) begin
            if (hit_dec) begin
               ctr_d[idx_dec] = ctr_upd;
               if (PCSrcD) begin
                  target_d[idx_dec] = PCBranchD;
               end else begin
                  target_d[idx_dec] = target_q[idx_dec];
               end
            end else if (PCSrcD) begin
               // Allocate on a taken miss, starting weakly taken.
               valid_d[idx_dec]  = 1'b1;
               tag_d[idx_dec]    = PCD[31:6];
               target_d[idx_dec] = PCBranchD;
               ctr_d[idx_dec]    = WT;
            end else begin
               valid_d[idx_dec] = valid_q[idx_dec];
            end
         end else if (pred_taken_q && hit_dec) begin
            // A non-branch hit its own stale entry; an alias at the same
            // index with a different tag is left alone.
            valid_d[idx_dec] = 1'b0;
         end else begin
            valid_d[idx_dec] = valid_q[idx_dec];
         end
      end else begin
         valid_d[idx_dec] = valid_q[idx_dec];
      end
   end

   // Table registers; reset clears every entry to invalid, weakly not taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BP_ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= 32'd0;
            ctr_q[i]    <= WNT;
         end
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         ctr_q    <= ctr_d;
      end
   end

   // F->D prediction register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_taken_q  <= 1'b0;
         pred_target_q <= 32'd0;
      end else begin
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
      end
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 PCF  in  32  fetch-stage PC (lookup address).
REQ-004 StallF  in  1  fetch stall; F->D prediction register holds.
REQ-005 StallD  in  1  decode stall; table update suppressed.
REQ-006 FlushD  in  1  decode flush; clears the F->D prediction register.
REQ-007 PCD  in  32  PC of the instruction in decode.
REQ-008 BranchD  in  1  decode instruction is a conditional branch.
REQ-009 PCSrcD  in  1  resolved branch outcome in decode (1 = taken).
REQ-010 PCBranchD  in  32  resolved branch target.
REQ-011 PreBr  out  1  predict-taken for PCF, drives the IF next-PC select.
REQ-012 PCPredictF  out  32  predicted target for PCF.
REQ-013 MispredictD  out  1  decode-stage prediction was wrong; flush F and redirect.
REQ-014 PCRecoverD  out  32  correct next PC when MispredictD=1.

Function
REQ-015 Table: 16 direct-mapped entries {valid, tag[25:0], target[31:0], ctr[1:0]}; index = PC[5:2], tag = PC[31:6].
REQ-016 Lookup is combinational: hit = valid && tag match on PCF[31:6]; PreBr = hit && ctr[1]; PCPredictF = entry target when hit, else PCF+4.
REQ-017 F->D register {PredTakenD, PredTargetD} loads {PreBr, PCPredictF} on clk when ~StallF && ~FlushD; clears to 0 when FlushD (FlushD wins over StallF); holds otherwise.
REQ-018 MispredictD = ~StallD && ((BranchD && PCSrcD != PredTakenD) || (BranchD && PCSrcD && PredTakenD && PCBranchD != PredTargetD) || (~BranchD && PredTakenD)).
REQ-019 PCRecoverD = (BranchD && PCSrcD) ? PCBranchD : PCD+4; valid only when MispredictD=1.
REQ-020 Update on clk when BranchD && ~StallD, indexed by PCD: hit -> ctr saturating +1 if taken, -1 if not taken; target <= PCBranchD if taken.
REQ-021 Miss && taken -> allocate: valid=1, tag=PCD[31:6], target=PCBranchD, ctr=10 (weakly taken). Miss && not taken -> no write.
REQ-022 ~BranchD && PredTakenD && ~StallD (alias or stale entry) -> invalidate the entry at PCD index if tag matches.
REQ-023 Counter saturates: 11 + taken stays 11; 00 + not taken stays 00.
REQ-024 Same-cycle update and lookup on the same index: lookup returns the pre-update contents; new contents visible the next cycle.
REQ-025 Exactly one update per decode instruction: no write while StallD=1.
REQ-026 MispredictD and PCRecoverD are combinational from the D register and the D inputs; zero-cycle latency within the decode stage.

Reset
REQ-027 On rst_n low, immediately and independent of clk: all valid=0, all ctr=01, all tag/target=0, PredTakenD=0, PredTargetD=0.
REQ-028 During reset: PreBr=0, PCPredictF=PCF+4, MispredictD=0.
REQ-029 Reset asserted mid-update discards the update; the table state after release is exactly the reset state.

Structure
REQ-030 Shared package bp_pkg SHALL hold BP_ENTRIES=16, BP_IDX_W=4, BP_TAG_W=26, and counter encodings SNT=00, WNT=01, WT=10, ST=11.
REQ-031 One sub-module bp_sat_ctr2 (2-bit saturating counter next-state, combinational) SHALL be used; table storage SHALL stay in branch_predictor.

Verification
REQ-032 Reset, then PCF=0x40 -> PreBr=0, PCPredictF=0x44.
REQ-033 Taken branch at PCD=0x40, target 0x80, table empty -> MispredictD=1, PCRecoverD=0x80; next cycle PCF=0x40 -> PreBr=1, PCPredictF=0x80.
REQ-034 Same branch not taken twice after allocation -> ctr 10->01->00; PreBr=0 after the first not-taken; each not-taken while predicted taken -> MispredictD=1, PCRecoverD=0x44.
REQ-035 Predicted taken, PCBranchD=0x90 with PredTargetD=0x80 -> MispredictD=1, PCRecoverD=0x90; entry target becomes 0x90.
REQ-036 StallD=1 for 3 cycles with BranchD=1 -> no ctr change and MispredictD=0; one update on release. FlushD=1 -> PredTakenD=0 next cycle.
REQ-037 Non-branch at 0x140 (aliases index of 0x40) with PredTakenD=1 -> MispredictD=1, PCRecoverD=0x144; entry for 0x40 left valid (tag mismatch).
